// File: rtl/core_pkg.sv
// core_pkg: shared CSR definitions for the RV32 core.
//   csr_op_e       CSR operation issued by the decoder
//   hpm_sel_t      5-bit mhpmevent selector value
//   CSR_* / *_BASE CSR addresses of the counter/performance-monitor block
//   csr_apply_op   read-modify-write value for WRITE/SET/CLEAR operations
package core_pkg;

  typedef enum logic [2:0] {
    NO_CSR_OP = 3'd0,
    WRITE_CSR = 3'd1,
    SET_CSR   = 3'd2,
    CLEAR_CSR = 3'd3,
    SYSTEM    = 3'd4
  } csr_op_e;

  typedef logic [4:0] hpm_sel_t;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  localparam logic [11:0] MHPMCOUNTER3_BASE  = 12'hB03;
  localparam logic [11:0] MHPMCOUNTER3H_BASE = 12'hB83;
  localparam logic [11:0] MHPMEVENT3_BASE    = 12'h323;
  localparam logic [11:0] HPMCOUNTER3_BASE   = 12'hC03;
  localparam logic [11:0] HPMCOUNTER3H_BASE  = 12'hC83;

  // New 32-bit CSR value for a write-class operation; read-only ops keep old.
  function automatic logic [31:0] csr_apply_op(input csr_op_e     op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] wdata);
    case (op)
      WRITE_CSR: return wdata;
      SET_CSR:   return old_val | wdata;
      CLEAR_CSR: return old_val & ~wdata;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter_unit_hpm_counter.sv
// hpm_counter: one CNT_WIDTH-bit machine counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         count request this cycle
//   inhibit     mcountinhibit bit for this counter
//   wr_lo       load bits [31:0] from wdata
//   wr_hi       load bits [CNT_WIDTH-1:32] from the low bits of wdata
//   wdata       32-bit write value
//   count       current counter value
// A write always wins over a same-cycle increment; the unwritten half keeps
// its old value (no carry between halves on a write). Wraps silently.
module hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 inhibit,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) count_d[31:0] = wdata;
      if (wr_hi) count_d[CNT_WIDTH-1:32] = wdata[HI_W-1:0];
    end else if (inc && !inhibit) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_counter_unit.sv
// csr_counter_unit: mcycle/minstret/mhpmcounter/mhpmevent/mcountinhibit CSRs
// with read-only user aliases.
//   clk, rst_n     clock, asynchronous active-low reset
//   csr_valid_i    CSR access this cycle
//   csr_op_i       operation; WRITE/SET/CLEAR write, others only read
//   csr_addr_i     CSR address
//   csr_wdata_i    write operand
//   csr_rdata_o    combinational read data (pre-write, pre-increment)
//   csr_hit_o      address owned by this block (including unimplemented hpm)
//   csr_illegal_o  write to a user alias, or access to unimplemented hpm index
//   retire_i       instruction retired (minstret increment)
//   event_i        event pulses selectable by mhpmevent
// Counter slot 1 (time) belongs to the platform timer and is tied off.
module csr_counter_unit
  import core_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_valid_i,
  input  csr_op_e               csr_op_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  output logic                  csr_illegal_o,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] event_i
);

  localparam int NUM_CNT = NUM_HPM + 3;
  localparam int EVT_N   = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [4:0] LAST_IDX = 5'(NUM_HPM + 2);
  // Inhibit bits backed by a real counter; bit 1 (time) never sticks.
  localparam logic [31:0] IMPL_MASK =
    ((NUM_CNT >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_CNT) - 32'd1)) & ~32'd2;

  // Address groups are 32-entry aligned windows; bits [4:0] give the index.
  localparam logic [6:0] GRP_MCNT  = MHPMCOUNTER3_BASE[11:5];
  localparam logic [6:0] GRP_MCNTH = MHPMCOUNTER3H_BASE[11:5];
  localparam logic [6:0] GRP_UCNT  = HPMCOUNTER3_BASE[11:5];
  localparam logic [6:0] GRP_UCNTH = HPMCOUNTER3H_BASE[11:5];
  localparam logic [6:0] GRP_EVT   = MHPMEVENT3_BASE[11:5];

  logic [4:0] idx;
  logic [6:0] grp;
  logic       cnt_addr, evt_addr, inh_addr, is_hi, is_user;
  logic       cnt_impl, evt_impl, is_wr_op;
  logic       hit, illegal, do_write;
  logic [31:0] rdata, wdata_new;

  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [CNT_WIDTH-1:0] sel_cnt;
  hpm_sel_t             sel_evt;
  hpm_sel_t             evt_sel_q [EVT_N];
  logic [31:0]          inhibit_q;
  logic [31:0]          evt_ext;
  logic [NUM_CNT-1:0]   cnt_inc, wr_lo, wr_hi;

  // Address decode
  always_comb begin
    idx      = csr_addr_i[4:0];
    grp      = csr_addr_i[11:5];
    is_hi    = (grp == GRP_MCNTH) || (grp == GRP_UCNTH);
    is_user  = (grp == GRP_UCNT)  || (grp == GRP_UCNTH);
    cnt_addr = ((grp == GRP_MCNT) || is_hi || is_user) && (idx != 5'd1);
    evt_addr = (grp == GRP_EVT) && (idx >= 5'd3);
    inh_addr = (csr_addr_i == CSR_MCOUNTINHIBIT);
    cnt_impl = (idx == 5'd0) || (idx == 5'd2) || ((idx >= 5'd3) && (idx <= LAST_IDX));
    evt_impl = (idx <= LAST_IDX);
    is_wr_op = (csr_op_i == WRITE_CSR) || (csr_op_i == SET_CSR) || (csr_op_i == CLEAR_CSR);
    hit      = cnt_addr || evt_addr || inh_addr;
    illegal  = csr_valid_i && ((cnt_addr && !cnt_impl) || (evt_addr && !evt_impl) ||
                               (cnt_addr && is_user && is_wr_op));
    do_write = csr_valid_i && hit && is_wr_op && !illegal;
  end

  // Read mux over registered state
  always_comb begin
    sel_cnt = '0;
    for (int k = 0; k < NUM_CNT; k++)
      if (idx == 5'(k)) sel_cnt = cnt[k];
    sel_evt = '0;
    for (int k = 0; k < NUM_HPM; k++)
      if (idx == 5'(k + 3)) sel_evt = evt_sel_q[k];
    rdata = '0;
    if (cnt_addr && cnt_impl) rdata = is_hi ? 32'(sel_cnt >> 32) : sel_cnt[31:0];
    else if (evt_addr && evt_impl) rdata = 32'(sel_evt);
    else if (inh_addr) rdata = inhibit_q;
  end

  assign wdata_new     = csr_apply_op(csr_op_i, rdata, csr_wdata_i);
  assign csr_rdata_o   = rdata;
  assign csr_hit_o     = csr_valid_i && hit;
  assign csr_illegal_o = illegal;

  // Increment sources; evt_ext bit e is event_i[e-1], bit 0 is selector "off".
  assign evt_ext = 32'({event_i, 1'b0});

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inc[2] = retire_i;
    for (int k = 3; k < NUM_CNT; k++)
      cnt_inc[k] = evt_ext[evt_sel_q[k-3]];
  end

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int k = 0; k < NUM_CNT; k++)
      if (do_write && cnt_addr && (idx == 5'(k))) begin
        wr_lo[k] = !is_hi;
        wr_hi[k] = is_hi;
      end
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (cnt_inc[k]),
      .inhibit (inhibit_q[k]),
      .wr_lo   (wr_lo[k]),
      .wr_hi   (wr_hi[k]),
      .wdata   (wdata_new),
      .count   (cnt[k])
    );
  end

  // Selector and inhibit registers; new values apply from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < EVT_N; k++) evt_sel_q[k] <= '0;
      inhibit_q <= '0;
    end else begin
      for (int k = 0; k < NUM_HPM; k++)
        if (do_write && evt_addr && (idx == 5'(k + 3))) evt_sel_q[k] <= wdata_new[4:0];
      if (do_write && inh_addr) inhibit_q <= wdata_new & IMPL_MASK;
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
module tb_csr_counter_unit;
  import core_pkg::*;

  localparam int NUM_HPM    = 4;
  localparam int CNT_WIDTH  = 64;
  localparam int NUM_EVENTS = 8;
  localparam longint unsigned CMASK =
    (CNT_WIDTH == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_WIDTH) - 64'd1);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  csr_valid_i;
  csr_op_e               csr_op_i;
  logic [11:0]           csr_addr_i;
  logic [31:0]           csr_wdata_i;
  logic [31:0]           csr_rdata_o;
  logic                  csr_hit_o;
  logic                  csr_illegal_o;
  logic                  retire_i;
  logic [NUM_EVENTS-1:0] event_i;

  always #5 clk = ~clk;

  csr_counter_unit #(.NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH), .NUM_EVENTS(NUM_EVENTS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_valid_i  (csr_valid_i),
    .csr_op_i     (csr_op_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_rdata_o  (csr_rdata_o),
    .csr_hit_o    (csr_hit_o),
    .csr_illegal_o(csr_illegal_o),
    .retire_i     (retire_i),
    .event_i      (event_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint unsigned m_cnt [32];
  int unsigned     m_sel [32];
  int unsigned     m_inh;

  function automatic bit impl(input int i);
    return (i == 0) || (i == 2) || (i >= 3 && i <= NUM_HPM + 2);
  endfunction

  // kind: 0 unowned, 1 counter, 2 event selector, 3 mcountinhibit
  function automatic void mdecode(input int a, output int kind, output int idx,
                                  output bit hi, output bit user);
    kind = 0; idx = 0; hi = 0; user = 0;
    if (a >= 'hB00 && a <= 'hB1F) begin kind = 1; idx = a - 'hB00; end
    else if (a >= 'hB80 && a <= 'hB9F) begin kind = 1; idx = a - 'hB80; hi = 1; end
    else if (a >= 'hC00 && a <= 'hC1F) begin kind = 1; idx = a - 'hC00; user = 1; end
    else if (a >= 'hC80 && a <= 'hC9F) begin kind = 1; idx = a - 'hC80; hi = 1; user = 1; end
    else if (a == 'h320) kind = 3;
    else if (a >= 'h323 && a <= 'h33F) begin kind = 2; idx = a - 'h320; end
    if (kind == 1 && idx == 1) kind = 0;
  endfunction

  function automatic longint unsigned mread(input int a);
    int kind, idx; bit hi, user;
    mdecode(a, kind, idx, hi, user);
    if (kind == 1 && impl(idx)) return hi ? (m_cnt[idx] >> 32) : (m_cnt[idx] & 64'hFFFF_FFFF);
    if (kind == 2 && impl(idx)) return m_sel[idx];
    if (kind == 3) return m_inh;
    return 0;
  endfunction

  function automatic bit is_wr(input csr_op_e op);
    return (op == WRITE_CSR) || (op == SET_CSR) || (op == CLEAR_CSR);
  endfunction

  function automatic bit mhit(input bit v, input int a);
    int kind, idx; bit hi, user;
    mdecode(a, kind, idx, hi, user);
    return v && (kind != 0);
  endfunction

  function automatic bit millegal(input bit v, input csr_op_e op, input int a);
    int kind, idx; bit hi, user;
    mdecode(a, kind, idx, hi, user);
    if (!v || kind == 0) return 0;
    if ((kind == 1 || kind == 2) && !impl(idx)) return 1;
    return user && is_wr(op);
  endfunction

  function automatic void mreset();
    for (int k = 0; k < 32; k++) begin m_cnt[k] = 0; m_sel[k] = 0; end
    m_inh = 0;
  endfunction

  // One clock edge of architectural behaviour, using the sampled inputs.
  function automatic void mstep();
    longint unsigned old [32];
    int kind, idx; bit hi, user, wr, ev;
    int unsigned o32, nv, imask;
    int a;
    a = int'(csr_addr_i);
    old = m_cnt;
    mdecode(a, kind, idx, hi, user);
    wr = csr_valid_i && is_wr(csr_op_i) && kind != 0 && !millegal(csr_valid_i, csr_op_i, a);
    o32 = int'(mread(a));
    case (csr_op_i)
      WRITE_CSR: nv = csr_wdata_i;
      SET_CSR:   nv = o32 | csr_wdata_i;
      CLEAR_CSR: nv = o32 & ~csr_wdata_i;
      default:   nv = o32;
    endcase
    for (int k = 0; k < 32; k++) begin
      if (impl(k) && !m_inh[k]) begin
        ev = (k == 0) || (k == 2 && retire_i);
        if (k >= 3 && m_sel[k] >= 1 && m_sel[k] <= NUM_EVENTS) ev = event_i[m_sel[k] - 1];
        if (ev) m_cnt[k] = (m_cnt[k] + 1) & CMASK;
      end
    end
    if (wr) begin
      if (kind == 1) begin
        if (hi) m_cnt[idx] = (old[idx] & 64'hFFFF_FFFF) | ((64'(nv) << 32) & CMASK);
        else    m_cnt[idx] = (old[idx] & ~64'hFFFF_FFFF) | 64'(nv);
      end else if (kind == 2) begin
        m_sel[idx] = nv & 31;
      end else begin
        imask = 0;
        for (int k = 0; k < 32; k++) if (impl(k)) imask |= (32'd1 << k);
        m_inh = nv & imask;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input csr_op_e op, input logic [11:0] a,
                       input logic [31:0] w, input bit r, input logic [NUM_EVENTS-1:0] e);
    csr_valid_i = v; csr_op_i = op; csr_addr_i = a; csr_wdata_i = w;
    retire_i = r; event_i = e;
  endtask

  task automatic idle();
    drive(1'b0, NO_CSR_OP, 12'h000, 32'h0, 1'b0, '0);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_val("rdata", csr_rdata_o, mread(int'(csr_addr_i)));
    check_val("hit", csr_hit_o, mhit(csr_valid_i, int'(csr_addr_i)));
    check_val("illegal", csr_illegal_o, millegal(csr_valid_i, csr_op_i, int'(csr_addr_i)));
    @(posedge clk);
    if (rst_n) mstep();
    #1;
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input longint unsigned exp);
    drive(1'b1, NO_CSR_OP, a, 32'h0, 1'b0, '0);
    #1;
    check_val(tag, csr_rdata_o, exp);
  endtask

  initial begin
    logic [11:0] ra;
    logic [31:0] rw;
    rst_n = 1'b0;
    mreset();
    drive(1'b0, NO_CSR_OP, CSR_MCYCLE, 32'h0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rdata", csr_rdata_o, 0);
    check_val("rst_hit", csr_hit_o, 0);
    check_val("rst_illegal", csr_illegal_o, 0);
    peek("rst_mcycle", CSR_MCYCLE, 0);

    // release and idle 10 cycles
    rst_n = 1'b1;
    idle();
    repeat (10) cycle();
    peek("mcycle_10", CSR_MCYCLE, 10);
    peek("minstret_0", CSR_MINSTRET, 0);

    // carry from low into high half
    drive(1'b1, WRITE_CSR, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, '0); cycle();
    drive(1'b1, WRITE_CSR, CSR_MCYCLEH, 32'h0, 1'b0, '0); cycle();
    idle(); cycle();
    peek("carry_lo", CSR_MCYCLE, 0);
    peek("carry_hi", CSR_MCYCLEH, 1);

    // full-width wrap
    drive(1'b1, WRITE_CSR, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, '0); cycle();
    drive(1'b1, WRITE_CSR, CSR_MCYCLEH, 32'hFFFF_FFFF, 1'b0, '0); cycle();
    idle(); cycle();
    peek("wrap_lo", CSR_MCYCLE, 0);
    peek("wrap_hi", CSR_MCYCLEH, 0);

    // event selection and inhibit
    drive(1'b1, WRITE_CSR, MHPMEVENT3_BASE, 32'd2, 1'b0, '0); cycle();
    drive(1'b0, NO_CSR_OP, 12'h0, 32'h0, 1'b0, 8'b10); repeat (5) cycle();
    drive(1'b0, NO_CSR_OP, 12'h0, 32'h0, 1'b0, 8'b01); repeat (3) cycle();
    peek("hpm3_5", MHPMCOUNTER3_BASE, 5);
    drive(1'b1, WRITE_CSR, CSR_MCOUNTINHIBIT, 32'h8, 1'b0, '0); cycle();
    drive(1'b0, NO_CSR_OP, 12'h0, 32'h0, 1'b0, 8'b10); repeat (4) cycle();
    peek("hpm3_inh", MHPMCOUNTER3_BASE, 5);

    // write wins over retire; set/clear
    drive(1'b1, WRITE_CSR, CSR_MINSTRET, 32'h100, 1'b1, '0); cycle();
    peek("instret_wr", CSR_MINSTRET, 32'h100);
    drive(1'b1, SET_CSR, CSR_MINSTRET, 32'h3, 1'b0, '0); cycle();
    peek("instret_set", CSR_MINSTRET, 32'h103);
    drive(1'b1, CLEAR_CSR, CSR_MINSTRET, 32'h100, 1'b0, '0); cycle();
    peek("instret_clr", CSR_MINSTRET, 32'h3);

    // inhibit everything
    drive(1'b1, WRITE_CSR, CSR_MCYCLE, 32'h1234, 1'b0, '0); cycle();
    drive(1'b1, WRITE_CSR, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 1'b0, '0); cycle();
    peek("inh_mask", CSR_MCOUNTINHIBIT, 32'h7D);
    idle(); repeat (3) cycle();
    peek("mcycle_frozen", CSR_MCYCLE, 32'h1235);

    // read-only aliases and unimplemented indices
    drive(1'b1, WRITE_CSR, CSR_CYCLE, 32'hABCD, 1'b0, '0); #1;
    check_val("ill_cycle", csr_illegal_o, 1);
    cycle();
    peek("cycle_kept", CSR_MCYCLE, 32'h1235);
    drive(1'b1, WRITE_CSR, HPMCOUNTER3_BASE, 32'h77, 1'b0, '0); #1;
    check_val("ill_hpm3", csr_illegal_o, 1);
    cycle();
    peek("hpm3_kept", MHPMCOUNTER3_BASE, 5);
    peek("uhpm3_rd", HPMCOUNTER3_BASE, 5);
    check_val("uhpm3_legal", csr_illegal_o, 0);
    peek("hpm10_rd", 12'hB0A, 0);
    check_val("hpm10_hit", csr_hit_o, 1);
    drive(1'b1, WRITE_CSR, 12'hB0A, 32'h55, 1'b0, '0); #1;
    check_val("ill_hpm10", csr_illegal_o, 1);
    cycle();

    drive(1'b1, WRITE_CSR, CSR_MCOUNTINHIBIT, 32'h0, 1'b0, '0); cycle();

    // randomized traffic against the model, with a mid-run async reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2;
        rst_n = 1'b0;
        mreset();
        peek("arst_mcycle", CSR_MCYCLE, 0);
        peek("arst_minstret", CSR_MINSTRET, 0);
        peek("arst_hpm3", MHPMCOUNTER3_BASE, 0);
        peek("arst_inh", CSR_MCOUNTINHIBIT, 0);
        cycle();
        rst_n = 1'b1;
      end
      rw = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(0, 7))
        0: ra = 12'(12'hB00 + $urandom_range(0, 31));
        1: ra = 12'(12'hB80 + $urandom_range(0, 31));
        2: ra = 12'(12'hC00 + $urandom_range(0, 31));
        3: ra = 12'(12'hC80 + $urandom_range(0, 31));
        4: ra = 12'(12'h320 + $urandom_range(0, 31));
        5: ra = 12'($urandom);
        6: ra = 12'(12'hB00 + $urandom_range(0, 6));
        default: begin
          ra = 12'(12'h323 + $urandom_range(0, 3));
          rw = $urandom_range(0, 9);
        end
      endcase
      drive($urandom_range(0, 3) != 0, csr_op_e'($urandom_range(0, 4)), ra, rw,
            1'($urandom), NUM_EVENTS'($urandom));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
